// File: rtl/pe_col_pipelined.sv
// PE column: AND-accumulates literal beats per (stage,slot) entry,
// then reduces finished clauses through a 2-stage OR tree.
module pe_col_pipelined #(
  parameter int N_PATCH   = 58,
  parameter int N_ELEMENT = 4,
  parameter int N_SLOT    = 2,
  parameter int OR_CHUNK  = 32,
  localparam int SW = $clog2(N_ELEMENT),
  localparam int LW = $clog2(N_SLOT),
  localparam int NE = N_ELEMENT * N_SLOT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SW-1:0]      in_stage,
  input  logic [LW-1:0]      in_slot,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               in_inv,
  input  logic [N_PATCH-1:0] in_literal,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SW-1:0]      res_stage,
  output logic [LW-1:0]      res_slot,
  output logic               res_fire,
  output logic [NE-1:0]      patch_result,
  output logic               err_no_first
);

  localparam int EW = SW + LW;
  localparam int NC = (N_PATCH + OR_CHUNK - 1) / OR_CHUNK;
  localparam int PW = NC * OR_CHUNK;

  logic [N_PATCH-1:0] spad [NE];
  logic [NE-1:0]      ev;

  logic               fire;
  logic [EW-1:0]      e;
  logic               open;
  logic [N_PATCH-1:0] lit;
  logic [N_PATCH-1:0] nxt;
  logic [PW-1:0]      pad;
  logic [NC-1:0]      chunk_or;

  logic               s1_valid;
  logic [NC-1:0]      s1_chunk;
  logic [SW-1:0]      s1_stage;
  logic [LW-1:0]      s1_slot;
  logic [EW-1:0]      s1_e;
  logic               s2_take;
  logic               s1_adv;

  assign fire     = in_valid & in_ready;
  assign e        = {in_stage, in_slot};
  assign s1_e     = {s1_stage, s1_slot};
  assign s2_take  = ~res_valid | res_ready;
  assign s1_adv   = s1_valid & s2_take;
  assign in_ready = ~s1_valid | s2_take;

  // Beat datapath: next AND value and first-level OR chunks
  always_comb begin
    lit  = in_inv ? ~in_literal : in_literal;
    open = ev[e] & ~clear;
    nxt  = (in_first | ~open) ? lit : (lit & spad[e]);
    pad  = '0;
    pad[N_PATCH-1:0] = nxt;
    for (int k = 0; k < NC; k++) begin
      chunk_or[k] = |pad[k*OR_CHUNK +: OR_CHUNK];
    end
  end

  // Scratchpad storage (no reset; guarded by entry-valid bits)
  always_ff @(posedge clk) begin
    if (fire) spad[e] <= nxt;
  end

  // Entry-valid bits and sticky missing-first flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev           <= '0;
      err_no_first <= 1'b0;
    end else if (clear) begin
      ev           <= '0;
      err_no_first <= 1'b0;
    end else if (fire) begin
      ev[e] <= ~in_last;
      if (~in_first & ~ev[e]) err_no_first <= 1'b1;
    end
  end

  // Stage 1: capture chunk ORs of a finished clause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_chunk <= '0;
      s1_stage <= '0;
      s1_slot  <= '0;
    end else if (fire & in_last) begin
      s1_valid <= 1'b1;
      s1_chunk <= chunk_or;
      s1_stage <= in_stage;
      s1_slot  <= in_slot;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: final OR into the held result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_fire  <= 1'b0;
      res_stage <= '0;
      res_slot  <= '0;
    end else if (s1_adv) begin
      res_valid <= 1'b1;
      res_fire  <= |s1_chunk;
      res_stage <= s1_stage;
      res_slot  <= s1_slot;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Per-entry copy of the last result, loaded with stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      patch_result <= '0;
    end else if (clear) begin
      patch_result <= '0;
    end else if (s1_adv) begin
      patch_result[s1_e] <= |s1_chunk;
    end
  end

endmodule
